// File: rtl/mips_pipe_cpu_hz.sv
// mips_pipe_cpu_hz: 5-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB) with
// hazard detection, load-use stall, BEQ resolved in EX with a 2-bubble flush,
// and external combinational instruction/data memory ports.
//
// Optional feature macro: MIPS_PIPE_FWD_EN
//   defined   : EX/MEM and MEM/WB results forwarded into EX operands; only
//               load-use hazards stall.
//   undefined : no forwarding; ID stalls while a source matches a writer in
//               EX or MEM (WB is covered by the regfile write-through).
//
// Ports:
//   clock, reset_n           rising-edge clock, async active-low reset
//   imem_addr / imem_rdata   instruction word address (PC[IMEM_AW+1:2]) / word
//   dmem_addr / dmem_wdata   data word address / store data
//   dmem_we / dmem_rdata     store strobe / load data
//   dbg_raddr / dbg_rdata    debug register-file read
//   retire                   valid instruction in WB this cycle
module mips_pipe_cpu_hz #(
  parameter int          IMEM_AW  = 10,
  parameter int          DMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_INSN = 32'h00000020
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  output logic               dmem_we,
  input  logic [31:0]        dmem_rdata,
  input  logic [4:0]         dbg_raddr,
  output logic [31:0]        dbg_rdata,
  output logic               retire
);

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_ir_q, ifid_ir_d, ifid_pc_q, ifid_pc_d;
  logic        ifid_v_q, ifid_v_d;
  logic [31:0] idex_ir_q, idex_ir_d, idex_pc_q, idex_pc_d;
  logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic        idex_v_q, idex_v_d;
  logic [31:0] exmem_alu_q, exmem_alu_d, exmem_b_q, exmem_b_d;
  logic [4:0]  exmem_dst_q, exmem_dst_d;
  logic        exmem_v_q, exmem_v_d, exmem_lw_q, exmem_lw_d, exmem_sw_q, exmem_sw_d;
  logic [31:0] memwb_val_q, memwb_val_d;
  logic [4:0]  memwb_dst_q, memwb_dst_d;
  logic        memwb_v_q, memwb_v_d;
  logic [31:0] regs_q [32];

  // ID decode and register read with WB write-through
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt;
  logic        id_uses_rt, wb_we;
  logic [31:0] id_a, id_b;
  assign id_op      = ifid_ir_q[31:26];
  assign id_rs      = ifid_ir_q[25:21];
  assign id_rt      = ifid_ir_q[20:16];
  assign id_uses_rt = (id_op == OP_R) || (id_op == OP_BEQ) || (id_op == OP_SW);
  // memwb_dst_q is zero for bubbles and non-writers, so it alone gates the write
  assign wb_we      = memwb_v_q && (memwb_dst_q != 5'd0);
  assign id_a = (wb_we && memwb_dst_q == id_rs) ? memwb_val_q : regs_q[id_rs];
  assign id_b = (wb_we && memwb_dst_q == id_rt) ? memwb_val_q : regs_q[id_rt];

  // EX decode
  logic [5:0]  ex_op, ex_funct;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dst;
  logic [31:0] ex_sext, ex_a, ex_b, ex_alu, ex_target;
  logic        ex_taken, ex_is_lw;
  assign ex_op    = idex_ir_q[31:26];
  assign ex_rs    = idex_ir_q[25:21];
  assign ex_rt    = idex_ir_q[20:16];
  assign ex_rd    = idex_ir_q[15:11];
  assign ex_funct = idex_ir_q[5:0];
  assign ex_sext  = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};
  assign ex_is_lw = idex_v_q && (ex_op == OP_LW);

  always_comb begin
    ex_dst = 5'd0;
    if (idex_v_q) begin
      if (ex_op == OP_R && (ex_funct == 6'd32 || ex_funct == 6'd34 || ex_funct == 6'd36 ||
                            ex_funct == 6'd37 || ex_funct == 6'd42))
        ex_dst = ex_rd;
      else if (ex_op == OP_LW)
        ex_dst = ex_rt;
    end
  end

`ifdef MIPS_PIPE_FWD_EN
  // A load in MEM never needs forwarding: the load-use stall keeps its consumer back a cycle.
  logic exmem_fwd_ok;
  assign exmem_fwd_ok = exmem_v_q && !exmem_lw_q && (exmem_dst_q != 5'd0);
  assign ex_a = (exmem_fwd_ok && exmem_dst_q == ex_rs) ? exmem_alu_q :
                (wb_we && memwb_dst_q == ex_rs)        ? memwb_val_q : idex_a_q;
  assign ex_b = (exmem_fwd_ok && exmem_dst_q == ex_rt) ? exmem_alu_q :
                (wb_we && memwb_dst_q == ex_rt)        ? memwb_val_q : idex_b_q;
`else
  assign ex_a = idex_a_q;
  assign ex_b = idex_b_q;
`endif

  always_comb begin
    ex_alu = 32'd0;
    if (ex_op == OP_R) begin
      case (ex_funct)
        6'd32:   ex_alu = ex_a + ex_b;
        6'd34:   ex_alu = ex_a - ex_b;
        6'd36:   ex_alu = ex_a & ex_b;
        6'd37:   ex_alu = ex_a | ex_b;
        6'd42:   ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
        default: ex_alu = 32'd0;
      endcase
    end else if (ex_op == OP_LW || ex_op == OP_SW) begin
      ex_alu = ex_a + ex_sext;
    end
  end

  assign ex_taken  = idex_v_q && (ex_op == OP_BEQ) && (ex_a == ex_b);
  assign ex_target = idex_pc_q + 32'd4 + {ex_sext[29:0], 2'b00};

  // Hazard detection against the decoded destinations downstream
  logic hit_ex, hit_mem, stall;
  assign hit_ex  = (ex_dst != 5'd0) &&
                   (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
  assign hit_mem = (exmem_dst_q != 5'd0) &&
                   (exmem_dst_q == id_rs || (id_uses_rt && exmem_dst_q == id_rt));
`ifdef MIPS_PIPE_FWD_EN
  assign stall = ifid_v_q && ex_is_lw && hit_ex;
`else
  assign stall = ifid_v_q && (hit_ex || hit_mem);
`endif

  always_comb begin
    pc_d      = pc_q + 32'd4;
    ifid_ir_d = imem_rdata;
    ifid_pc_d = pc_q;
    ifid_v_d  = 1'b1;
    idex_ir_d = ifid_ir_q;
    idex_pc_d = ifid_pc_q;
    idex_a_d  = id_a;
    idex_b_d  = id_b;
    idex_v_d  = ifid_v_q;
    // A taken branch is older than the stalled instruction, so it wins.
    if (ex_taken) begin
      pc_d      = ex_target;
      ifid_ir_d = NOP_INSN;
      ifid_v_d  = 1'b0;
      idex_ir_d = NOP_INSN;
      idex_v_d  = 1'b0;
    end else if (stall) begin
      pc_d      = pc_q;
      ifid_ir_d = ifid_ir_q;
      ifid_pc_d = ifid_pc_q;
      ifid_v_d  = ifid_v_q;
      idex_ir_d = NOP_INSN;
      idex_v_d  = 1'b0;
    end
    exmem_alu_d = ex_alu;
    exmem_b_d   = ex_b;
    exmem_dst_d = ex_dst;
    exmem_v_d   = idex_v_q;
    exmem_lw_d  = ex_is_lw;
    exmem_sw_d  = idex_v_q && (ex_op == OP_SW);
    memwb_val_d = exmem_lw_q ? dmem_rdata : exmem_alu_q;
    memwb_dst_d = exmem_dst_q;
    memwb_v_d   = exmem_v_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q        <= RESET_PC;
      ifid_ir_q   <= NOP_INSN;
      ifid_pc_q   <= 32'd0;
      ifid_v_q    <= 1'b0;
      idex_ir_q   <= NOP_INSN;
      idex_pc_q   <= 32'd0;
      idex_a_q    <= 32'd0;
      idex_b_q    <= 32'd0;
      idex_v_q    <= 1'b0;
      exmem_alu_q <= 32'd0;
      exmem_b_q   <= 32'd0;
      exmem_dst_q <= 5'd0;
      exmem_v_q   <= 1'b0;
      exmem_lw_q  <= 1'b0;
      exmem_sw_q  <= 1'b0;
      memwb_val_q <= 32'd0;
      memwb_dst_q <= 5'd0;
      memwb_v_q   <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_ir_q   <= ifid_ir_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_v_q    <= ifid_v_d;
      idex_ir_q   <= idex_ir_d;
      idex_pc_q   <= idex_pc_d;
      idex_a_q    <= idex_a_d;
      idex_b_q    <= idex_b_d;
      idex_v_q    <= idex_v_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_b_q   <= exmem_b_d;
      exmem_dst_q <= exmem_dst_d;
      exmem_v_q   <= exmem_v_d;
      exmem_lw_q  <= exmem_lw_d;
      exmem_sw_q  <= exmem_sw_d;
      memwb_val_q <= memwb_val_d;
      memwb_dst_q <= memwb_dst_d;
      memwb_v_q   <= memwb_v_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'(i);
    end else if (wb_we) begin
      regs_q[memwb_dst_q] <= memwb_val_q;
    end
  end

  assign imem_addr  = pc_q[IMEM_AW+1:2];
  assign dmem_addr  = exmem_alu_q[DMEM_AW+1:2];
  assign dmem_wdata = exmem_b_q;
  assign dmem_we    = exmem_sw_q;
  assign dbg_rdata  = regs_q[dbg_raddr];
  assign retire     = memwb_v_q;

endmodule

// File: tb/tb_mips_pipe_cpu_hz.sv
module tb_mips_pipe_cpu_hz;

  localparam logic [31:0] NOP = 32'h00000020;

  logic        clock;
  logic        reset_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        retire;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  mips_pipe_cpu_hz dut (
    .clock(clock), .reset_n(reset_n),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .retire(retire)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] i0, i1, i2;
    logic [4:0]  r;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  vec_t vecs[$];
  st_t  sb[$];
  int   ret_cyc[$];
  int   cyc;
  int   n_cmp;
  int   n_fail;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] i0, i1, i2,
                         input logic [4:0] r, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.i0 = i0; v.i1 = i1; v.i2 = i2; v.r = r; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic clear_mems();
    for (int k = 0; k < 1024; k++) begin
      imem[k] = NOP;
      dmem[k] = 32'd0;
    end
    sb.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    ret_cyc.delete();
  endtask

  // One cycle: record retirements, model the data memory and check stores against the scoreboard.
  task automatic step();
    st_t e;
    @(negedge clock);
    cyc++;
    if (retire) ret_cyc.push_back(cyc);
    if (dmem_we) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected store: addr %h data %h at cycle %0d", dmem_addr, dmem_wdata, cyc);
      end else begin
        e = sb.pop_front();
        chk("store addr", 32'(dmem_addr), e.addr);
        chk("store data", dmem_wdata, e.data);
      end
      dmem[dmem_addr] = dmem_wdata;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic chk_reg(input string name, input logic [4:0] r, input logic [31:0] exp);
    dbg_raddr = r;
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  function automatic int rc(input int k);
    return (ret_cyc.size() > k) ? ret_cyc[k] : -1;
  endfunction

  initial begin
    st_t e;
    int  gap_exp;
    n_cmp = 0;
    n_fail = 0;
    cyc = 0;
    reset_n = 1'b0;
    dbg_raddr = 5'd0;

    add_vec("add",        rtype(1, 2, 3, 32), NOP, NOP, 3, 32'd3);
    add_vec("sub wrap",   rtype(2, 7, 5, 34), NOP, NOP, 5, 32'hFFFFFFFB);
    add_vec("and",        rtype(13, 11, 9, 36), NOP, NOP, 9, 32'd9);
    add_vec("or",         rtype(12, 3, 10, 37), NOP, NOP, 10, 32'd15);
    add_vec("slt false",  rtype(7, 2, 8, 42), NOP, NOP, 8, 32'd0);
    add_vec("slt true",   rtype(2, 7, 8, 42), NOP, NOP, 8, 32'd1);
    add_vec("slt neg",    rtype(0, 1, 20, 34), rtype(20, 1, 21, 42), NOP, 21, 32'd1);
    add_vec("slt neg rev", rtype(0, 1, 20, 34), rtype(1, 20, 21, 42), NOP, 21, 32'd0);
    add_vec("dep add",    rtype(1, 2, 3, 32), rtype(3, 3, 4, 32), NOP, 4, 32'd6);
    add_vec("r0 write",   rtype(1, 1, 0, 32), NOP, NOP, 0, 32'd0);
    add_vec("same dst",   rtype(1, 2, 5, 32), rtype(5, 1, 5, 34), NOP, 5, 32'd2);
    add_vec("bad funct",  rtype(1, 2, 14, 38), NOP, NOP, 14, 32'd14);
    add_vec("bad opcode", itype(6'h08, 1, 15, 16'd5), NOP, NOP, 15, 32'd15);
    add_vec("memwb fwd",  rtype(1, 2, 16, 32), NOP, rtype(16, 1, 17, 32), 17, 32'd4);

    // Test 1: reset and free-running fetch
    clear_mems();
    do_reset();
    chk("t1 imem_addr c0", 32'(imem_addr), 32'd0);
    chk("t1 retire c0", 32'(retire), 32'd0);
    chk_reg("t1 r5", 5'd5, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk($sformatf("t1 imem_addr c%0d", k), 32'(imem_addr), 32'(k));
      chk($sformatf("t1 retire c%0d", k), 32'(retire), (k >= 4) ? 32'd1 : 32'd0);
    end

    // ALU / dependency vectors
    foreach (vecs[i]) begin
      clear_mems();
      imem[0] = vecs[i].i0;
      imem[1] = vecs[i].i1;
      imem[2] = vecs[i].i2;
      do_reset();
      run(15);
      chk_reg(vecs[i].name, vecs[i].r, vecs[i].exp);
    end

    // Test 2: back-to-back dependency timing
`ifdef MIPS_PIPE_FWD_EN
    gap_exp = 1;
`else
    gap_exp = 3;
`endif
    clear_mems();
    imem[0] = rtype(1, 2, 3, 32);
    imem[1] = rtype(3, 3, 4, 32);
    do_reset();
    run(12);
    chk("t2 first retire cycle", 32'(rc(0)), 32'd4);
    chk("t2 retire gap", 32'(rc(1) - rc(0)), 32'(gap_exp));
    chk_reg("t2 r3", 5'd3, 32'd3);
    chk_reg("t2 r4", 5'd4, 32'd6);

    // Test 3: load-use
`ifdef MIPS_PIPE_FWD_EN
    gap_exp = 2;
`else
    gap_exp = 3;
`endif
    clear_mems();
    dmem[0] = 32'h1234;
    imem[0] = itype(6'h23, 0, 6, 16'd0);
    imem[1] = rtype(6, 6, 7, 32);
    do_reset();
    run(12);
    chk("t3 retire gap", 32'(rc(1) - rc(0)), 32'(gap_exp));
    chk_reg("t3 r6", 5'd6, 32'h1234);
    chk_reg("t3 r7", 5'd7, 32'h2468);

    // Test 4: stores through the scoreboard
    clear_mems();
    imem[0] = itype(6'h2B, 0, 2, 16'd8);
    imem[1] = itype(6'h2B, 0, 2, 16'hFFFC);
    imem[2] = rtype(1, 2, 9, 32);
    imem[3] = itype(6'h2B, 0, 9, 16'd16);
    imem[4] = rtype(1, 1, 0, 32);
    imem[5] = itype(6'h23, 0, 10, 16'd16);
    e.addr = 32'd2;     e.data = 32'd2; sb.push_back(e);
    e.addr = 32'h3FF;   e.data = 32'd2; sb.push_back(e);
    e.addr = 32'd4;     e.data = 32'd3; sb.push_back(e);
    do_reset();
    run(20);
    chk("t4 stores outstanding", 32'(sb.size()), 32'd0);
    chk_reg("t4 r0", 5'd0, 32'd0);
    chk_reg("t4 r10", 5'd10, 32'd3);

    // Test 5a: taken branch at byte 0x10
    clear_mems();
    imem[4] = itype(6'h04, 1, 1, 16'd2);
    imem[5] = rtype(1, 1, 11, 32);
    imem[6] = rtype(1, 1, 12, 32);
    imem[7] = rtype(1, 2, 13, 32);
    do_reset();
    run(7);
    chk("t5 fetch after branch", 32'(imem_addr), 32'd7);
    step();
    chk("t5 retire beq", 32'(retire), 32'd1);
    step();
    chk("t5 bubble 1", 32'(retire), 32'd0);
    step();
    chk("t5 bubble 2", 32'(retire), 32'd0);
    step();
    chk("t5 retire target", 32'(retire), 32'd1);
    run(6);
    chk_reg("t5 r11 untouched", 5'd11, 32'd11);
    chk_reg("t5 r12 untouched", 5'd12, 32'd12);
    chk_reg("t5 r13", 5'd13, 32'd3);

    // Test 5b: branch not taken
    clear_mems();
    imem[4] = itype(6'h04, 1, 2, 16'd2);
    imem[5] = rtype(1, 1, 11, 32);
    imem[6] = rtype(1, 1, 12, 32);
    do_reset();
    run(7);
    chk("t5n fetch sequential", 32'(imem_addr), 32'd7);
    run(2);
    chk("t5n retire c9", 32'(retire), 32'd1);
    step();
    chk("t5n retire c10", 32'(retire), 32'd1);
    run(4);
    chk_reg("t5n r11", 5'd11, 32'd2);
    chk_reg("t5n r12", 5'd12, 32'd2);

    // Test 6: reset mid-program, store in flight must not complete
    clear_mems();
    dmem[0] = 32'h1234;
    imem[0] = itype(6'h23, 0, 6, 16'd0);
    imem[1] = rtype(6, 6, 7, 32);
    imem[2] = itype(6'h2B, 0, 7, 16'd0);
    do_reset();
    run(3);
    reset_n = 1'b0;
    #1;
    chk("t6 imem_addr", 32'(imem_addr), 32'd0);
    chk("t6 retire", 32'(retire), 32'd0);
    chk("t6 dmem_we", 32'(dmem_we), 32'd0);
    chk_reg("t6 r7", 5'd7, 32'd7);
    run(6);
    chk("t6 dmem[0] intact", dmem[0], 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
